// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the custom_axi_ip datapath and its job scheduler.
// - status_e      : status reported by the custom_axi_ip instance
// - sched_state_e : scheduler FSM states
// - rr_next       : wrap-around increment used for the round-robin pointer
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 32'sd1) % n;
  endfunction

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// Combinational round-robin arbiter.
// - req_i   : request vector, one bit per requester
// - ptr_i   : highest-priority index for this decision
// - en_i    : when low, no grant is issued
// - grant_o : one-hot grant
// - idx_o   : index of the winner (0 when nothing granted)
// - any_o   : a grant was issued
module custom_axi_ip_rr_arb
  import custom_axi_ip_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // Scan upward from the pointer with wrap; the first valid requester wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/custom_axi_ip_sched.sv
// Round-robin job scheduler sharing one custom_axi_ip datapath between
// NUM_REQ requesters. One job is outstanding at a time.
// - clk_i / rst_i            : clock, synchronous active-high reset
// - req_valid_i/req_data_i   : per-requester jobs (slice i = requester i)
// - req_ready_o              : one-hot accept pulse, only in S_IDLE
// - rsp_*                    : shared response channel (valid/ready)
// - ip_data_o/ip_enable_o    : job data and one-cycle start pulse to the IP
// - ip_data_i/ip_status_i    : result and status from the IP
// - busy_o                   : a job is in flight
module custom_axi_ip_sched
  import custom_axi_ip_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          rsp_timeout_o,
  output logic [DATA_WIDTH-1:0]         ip_data_o,
  output logic                          ip_enable_o,
  input  logic [DATA_WIDTH-1:0]         ip_data_i,
  input  status_e                       ip_status_i,
  output logic                          busy_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e          state_r, state_next_s;
  logic [ID_W-1:0]       ptr_r, job_id_r, win_idx_s;
  logic [DATA_WIDTH-1:0] job_data_r, rsp_data_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  rsp_err_r, rsp_timeout_r;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  any_grant_s, arb_en_s;
  logic [DATA_WIDTH-1:0] req_data_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_data_s[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Grants only while idle and the IP itself reports idle.
  assign arb_en_s = (state_r == S_IDLE) && (ip_status_i == IDLE);

  custom_axi_ip_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_r),
    .en_i    (arb_en_s),
    .grant_o (grant_s),
    .idx_o   (win_idx_s),
    .any_o   (any_grant_s)
  );

  assign req_ready_o   = grant_s;
  assign ip_enable_o   = (state_r == S_ISSUE);
  assign ip_data_o     = ((state_r == S_ISSUE) || (state_r == S_WAIT)) ? job_data_r : '0;
  assign rsp_valid_o   = (state_r == S_RESP);
  assign rsp_id_o      = job_id_r;
  assign rsp_data_o    = rsp_data_r;
  assign rsp_err_o     = rsp_err_r;
  assign rsp_timeout_o = rsp_timeout_r;
  assign busy_o        = (state_r != S_IDLE);

  // Next-state decode for the job lifecycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (any_grant_s) state_next_s = S_ISSUE;
        else             state_next_s = S_IDLE;
      end
      S_ISSUE: state_next_s = S_WAIT;
      S_WAIT: begin
        if ((ip_status_i == DONE) || (ip_status_i == ERROR) || (cnt_r == CNT_LAST))
          state_next_s = S_RESP;
        else
          state_next_s = S_WAIT;
      end
      S_RESP: begin
        if (rsp_ready_i) state_next_s = S_IDLE;
        else             state_next_s = S_RESP;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, job latches, timeout counter and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= S_IDLE;
      ptr_r         <= '0;
      job_id_r      <= '0;
      job_data_r    <= '0;
      cnt_r         <= '0;
      rsp_data_r    <= '0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (any_grant_s) begin
        ptr_r      <= ID_W'(rr_next(int'(win_idx_s), NUM_REQ));
        job_id_r   <= win_idx_s;
        job_data_r <= req_data_s[win_idx_s];
      end
      if (state_r == S_WAIT) begin
        if (state_next_s == S_RESP) begin
          cnt_r <= '0;
          // DONE outranks ERROR, which outranks the timeout.
          if (ip_status_i == DONE) begin
            rsp_data_r    <= ip_data_i;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
          end else if (ip_status_i == ERROR) begin
            rsp_data_r    <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b0;
          end else begin
            rsp_data_r    <= '0;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
          end
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_sched.sv
module tb_custom_axi_ip_sched;
  import custom_axi_ip_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_ready_o;
  logic            rsp_valid_o, rsp_ready_i;
  logic [1:0]      rsp_id_o;
  logic [DW-1:0]   rsp_data_o, ip_data_o, ip_data_i;
  logic            rsp_err_o, rsp_timeout_o, ip_enable_o, busy_o;
  status_e         st = IDLE;

  logic [DW-1:0] job_data [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data_i[g*DW +: DW] = job_data[g];
  end

  // IP model controls: mode 0 = DONE, 1 = ERROR, 2 = stays BUSY
  int            mode  = 0;
  int            delay = 3;
  int            cd    = 0;
  logic [DW-1:0] res   = '0;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          err;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   grant_q[$];
  int   tests = 0, fails = 0, en_cnt = 0, g_total = 0;

  custom_axi_ip_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .ip_data_o(ip_data_o), .ip_enable_o(ip_enable_o), .ip_data_i(ip_data_i),
    .ip_status_i(st), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign ip_data_i = (st == DONE) ? res : 32'hBAD0_BAD0;

  // Behavioural IP: result = job + 1, reported `delay` cycles after enable
  always @(posedge clk_i) begin
    if (rst_i) begin
      st <= IDLE;
      cd <= 0;
    end else if (ip_enable_o) begin
      st  <= BUSY;
      cd  <= delay - 1;
      res <= ip_data_o + 32'd1;
    end else begin
      case (st)
        BUSY: begin
          if (rsp_valid_o) st <= IDLE;
          else if (mode != 2) begin
            if (cd <= 1) st <= (mode == 1) ? ERROR : DONE;
            else         cd <= cd - 1;
          end
        end
        DONE, ERROR: st <= IDLE;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: push expectations on grant, pop and compare on response handshake
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (!rst_i) begin
      chk("grant_onehot", 64'($onehot0(req_ready_o)), 64'd1);
      if (ip_enable_o) en_cnt++;
      for (int i = 0; i < N; i++) begin
        if (req_ready_o[i[1:0]]) begin
          e.id   = i[1:0];
          e.data = (mode == 0) ? job_data[i[1:0]] + 32'd1 : 32'd0;
          e.err  = (mode != 0);
          e.to   = (mode == 2);
          sb.push_back(e);
          grant_q.push_back(i);
          g_total++;
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",      64'(rsp_id_o),      64'(e.id));
          chk("rsp_data",    64'(rsp_data_o),    64'(e.data));
          chk("rsp_err",     64'(rsp_err_o),     64'(e.err));
          chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_grant(input logic [1:0] r, input string tag);
    int n = 0;
    do begin @(negedge clk_i); n++; end while (!req_ready_o[r] && n < 300);
    chk(tag, 64'(req_ready_o[r]), 64'd1);
  endtask

  task automatic wait_enable(output int n);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!ip_enable_o && n < 300);
  endtask

  task automatic count_to_rsp(output int n);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!rsp_valid_o && n < 300);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    do begin @(negedge clk_i); n++; end while ((busy_o || sb.size() != 0) && n < 400);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n, e0;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e0;
    rst_i = 1'b1; req_valid_i = '0; rsp_ready_i = 1'b1;
    for (int i = 0; i < N; i++) job_data[i[1:0]] = 32'd0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy",      64'(busy_o),        64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o),   64'd0);
    chk("rst_req_ready", 64'(req_ready_o),   64'd0);
    chk("rst_enable",    64'(ip_enable_o),   64'd0);
    chk("rst_ip_data",   64'(ip_data_o),     64'd0);
    chk("rst_rsp_data",  64'(rsp_data_o),    64'd0);
    chk("rst_rsp_id",    64'(rsp_id_o),      64'd0);
    chk("rst_rsp_err",   64'(rsp_err_o),     64'd0);
    chk("rst_rsp_to",    64'(rsp_timeout_o), 64'd0);

    // Single job on requester 0, DONE three cycles after enable
    mode = 0; delay = 3; e0 = en_cnt;
    tick(); job_data[0] = 32'h0000_0010; req_valid_i = 4'b0001;
    wait_grant(2'd0, "single_grant");
    tick(); req_valid_i = '0;
    wait_enable(n);
    chk("single_enable_lat", 64'(n), 64'd1);
    chk("single_ip_data",    64'(ip_data_o), 64'h10);
    count_to_rsp(n);
    chk("single_rsp_lat", 64'(n), 64'd4);
    chk("single_rsp_data", 64'(rsp_data_o), 64'h11);
    drain("single_drain");
    chk("single_one_enable", 64'(en_cnt - e0), 64'd1);

    // Round robin from pointer 0 with all requesters continuously valid
    tick(); rst_i = 1'b1; tick(); rst_i = 1'b0;
    grant_q.delete();
    for (int i = 0; i < N; i++) job_data[i[1:0]] = 32'h100 * (i + 1);
    req_valid_i = 4'b1111;
    n = 0;
    do begin @(negedge clk_i); n++; end while (grant_q.size() < 5 && n < 400);
    tick(); req_valid_i = '0;
    drain("rr_drain");
    chk("rr_count", 64'(grant_q.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < grant_q.size()) chk("rr_order", 64'(grant_q[k]), 64'(k % 4));

    // Error path on requester 1
    mode = 1; delay = 2;
    tick(); job_data[1] = 32'h0000_000E; req_valid_i = 4'b0010;
    wait_grant(2'd1, "err_grant");
    tick(); req_valid_i = '0;
    count_to_rsp(n);
    chk("err_err",  64'(rsp_err_o),     64'd1);
    chk("err_to",   64'(rsp_timeout_o), 64'd0);
    chk("err_data", 64'(rsp_data_o),    64'd0);
    drain("err_drain");

    // Timeout on requester 3: IP never finishes
    mode = 2;
    tick(); job_data[3] = 32'hCAFE_0003; req_valid_i = 4'b1000;
    wait_grant(2'd3, "to_grant");
    tick(); req_valid_i = '0;
    wait_enable(n);
    count_to_rsp(n);
    chk("to_latency", 64'(n), 64'd65);
    chk("to_err",  64'(rsp_err_o),     64'd1);
    chk("to_flag", 64'(rsp_timeout_o), 64'd1);
    chk("to_data", 64'(rsp_data_o),    64'd0);
    drain("to_drain");

    // Backpressure: response held 10 cycles while requester 2 waits
    mode = 0; delay = 3;
    tick(); rsp_ready_i = 1'b0; job_data[1] = 32'h0000_0055; req_valid_i = 4'b0010;
    wait_grant(2'd1, "bp_grant1");
    tick(); req_valid_i = '0;
    count_to_rsp(n);
    tick(); job_data[2] = 32'h0000_0077; req_valid_i = 4'b0100;
    repeat (10) begin
      @(negedge clk_i);
      chk("bp_valid",     64'(rsp_valid_o), 64'd1);
      chk("bp_id",        64'(rsp_id_o),    64'd1);
      chk("bp_data",      64'(rsp_data_o),  64'h56);
      chk("bp_err",       64'(rsp_err_o),   64'd0);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
    end
    tick(); rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_hs_no_grant", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    chk("bp_grant2", 64'(req_ready_o), 64'b0100);
    tick(); req_valid_i = '0;
    drain("bp_drain");

    // Reset while waiting on the IP: job discarded, pointer back to 0
    mode = 2;
    tick(); job_data[1] = 32'h0000_0099; req_valid_i = 4'b0010;
    wait_grant(2'd1, "rw_grant");
    tick(); req_valid_i = '0;
    wait_enable(n);
    repeat (3) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    sb.delete();
    repeat (5) begin
      @(negedge clk_i);
      chk("rw_no_rsp", 64'(rsp_valid_o), 64'd0);
      chk("rw_busy",   64'(busy_o),      64'd0);
    end
    mode = 0; delay = 1;
    tick(); job_data[0] = 32'h0000_0005; job_data[3] = 32'h0000_0003; req_valid_i = 4'b1001;
    @(negedge clk_i);
    chk("rw_lowest_grant", 64'(req_ready_o), 64'b0001);
    tick(); req_valid_i = 4'b1000;
    wait_grant(2'd3, "rw_grant3");
    tick(); req_valid_i = '0;
    drain("rw_drain");

    chk("enable_per_grant", 64'(en_cnt), 64'(g_total));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
